// File: rtl/keypad_decoder.sv
// Keypad decoder: debounces the scanner's one-hot key bus, reports one event per press
// as a 4-bit code, and buffers the events in a small FIFO with a valid/ready handshake.
module keypad_decoder #(
    parameter int DEBOUNCE   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [11:0] key_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [3:0]  out_code_o,
    output logic        key_held_o,
    output logic        multi_err_o,
    output logic        overflow_o
);

    localparam int CW = $clog2(DEBOUNCE);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW:0]   COUNT_ONE = (PW + 1)'(1);
    localparam logic [PW:0]   DEPTH_C   = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        WAIT_REL
    } state_t;

    logic [11:0]   samp_q;
    logic [11:0]   cand_q;
    logic [11:0]   stable_q;
    logic [11:0]   held_q;
    logic [CW-1:0] cnt_q;
    state_t        state_q;
    logic          key_held_q;
    logic          multi_err_q;
    logic          overflow_q;
    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;

    logic is_one_hot;
    logic push;
    logic pop;
    logic full;
    logic accept;

    // Bit positions 0..8 are keys 1..9; bits 9, 10, 11 are '*', '0', '#'.
    function automatic logic [3:0] encode(input logic [11:0] k);
        logic [3:0] c;
        c = 4'h0;
        for (int i = 0; i < 9; i++) begin
            if (k[i]) c = 4'(i + 1);
        end
        if (k[9])  c = 4'hA;
        if (k[10]) c = 4'h0;
        if (k[11]) c = 4'hB;
        return c;
    endfunction

    always_comb begin
        is_one_hot = (stable_q != 12'd0) && ((stable_q & (stable_q - 12'd1)) == 12'd0);
        push       = (state_q == IDLE) && is_one_hot;
        full       = (count_q == DEPTH_C);
        pop        = (count_q != '0) && out_ready_i;
        accept     = push && (!full || pop);
    end

    // A sampled value must repeat DEBOUNCE times in a row before it replaces the stable value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            samp_q   <= '0;
            cand_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            samp_q <= key_data_i;
            if (samp_q != cand_q) begin
                cand_q <= samp_q;
                cnt_q  <= '0;
            end else if (cnt_q == CNT_MAX) begin
                stable_q <= cand_q;
            end else begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            held_q      <= '0;
            key_held_q  <= 1'b0;
            multi_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            multi_err_q <= 1'b0;
            overflow_q  <= push && full && !pop;
            case (state_q)
                IDLE: begin
                    if (is_one_hot) begin
                        held_q     <= stable_q;
                        state_q    <= PRESSED;
                        key_held_q <= 1'b1;
                    end else if (stable_q != 12'd0) begin
                        multi_err_q <= 1'b1;
                        state_q     <= WAIT_REL;
                    end
                end
                PRESSED: begin
                    // Rollover to another key is not reported; wait for a full release.
                    if (stable_q == 12'd0) begin
                        state_q    <= IDLE;
                        key_held_q <= 1'b0;
                    end else if (stable_q != held_q) begin
                        state_q    <= WAIT_REL;
                        key_held_q <= 1'b0;
                    end
                end
                WAIT_REL: begin
                    if (stable_q == 12'd0) state_q <= IDLE;
                end
                default: begin
                    state_q    <= IDLE;
                    key_held_q <= 1'b0;
                end
            endcase
        end
    end

    // A full FIFO still accepts a push when the consumer pops in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                mem_q[wr_ptr_q] <= encode(stable_q);
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({accept, pop})
                2'b10:   count_q <= count_q + COUNT_ONE;
                2'b01:   count_q <= count_q - COUNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    assign out_valid_o = (count_q != '0);
    assign out_code_o  = mem_q[rd_ptr_q];
    assign key_held_o  = key_held_q;
    assign multi_err_o = multi_err_q;
    assign overflow_o  = overflow_q;

endmodule

// File: doc/keypad_decoder.md
Name: keypad_decoder

Overview:
- Sits directly downstream of the 4x3 keypad scanner and consumes its 12-bit one-hot key_data bus.
- Debounces the bus, detects a single key-down event per physical press, and encodes the key to a 4-bit code.
- Buffers events in a 4-entry FIFO with a valid/ready output interface for the term-project control logic (digit entry and display).

Parameters:
- DEBOUNCE, 16, consecutive clk cycles a sampled value must stay unchanged before it is accepted as stable (legal range 2..1023).
- FIFO_DEPTH, 4, number of buffered key events; must be a power of two.

Ports:
- clk  input  1  system clock, same clock that drives the keypad scanner.
- rst  input  1  asynchronous active-low reset.
- key_data  input  12  one-hot key bus from scanner; bit0..bit8 = keys 1..9, bit9 = *, bit10 = 0, bit11 = #.
- out_valid  output  1  FIFO non-empty; out_code is valid.
- out_ready  input  1  consumer accepts out_code on a cycle with out_valid && out_ready.
- out_code  output  4  key code: digits 0..9 map to 4'h0..4'h9, * maps to 4'hA, # maps to 4'hB.
- key_held  output  1  high while a valid key is debounced-pressed.
- multi_err  output  1  one-cycle pulse when a stable multi-hot pattern is accepted.
- overflow  output  1  one-cycle pulse when an event is dropped because the FIFO is full.

Behaviour:
- Reset: clk and rst only. Reset is asynchronous, active-low. While rst=0, all registers clear: sample, candidate, stable, counter, FSM = IDLE, FIFO pointers/count = 0. Output reset values are out_valid=0, out_code=0, key_held=0, multi_err=0, overflow=0.
- Sampling: key_data is registered once into samp on every clk edge. It is treated as synchronous, since the scanner runs from the same clk.
- Debounce:
  - If samp != cand: cand <= samp and cnt <= 0.
  - Otherwise cnt increments, saturating at DEBOUNCE-1.
  - When cnt reaches DEBOUNCE-1, stable <= cand.
- FSM states: IDLE, PRESSED, WAIT_REL.
  - IDLE, stable == 0: stay.
  - IDLE, stable exactly one-hot: push encoded code into FIFO; go to PRESSED.
  - IDLE, stable multi-hot: pulse multi_err; go to WAIT_REL; no push.
  - PRESSED, stable == 0: go to IDLE.
  - PRESSED, stable changes to a different nonzero value without passing through 0: go to WAIT_REL; no push. Rollover is not supported.
  - WAIT_REL, stable == 0: go to IDLE.
  - key_held = (state == PRESSED).
- Each physical press yields exactly one event, regardless of how long the key is held (no auto-repeat).
- Latency: out_valid rises on the clk edge DEBOUNCE+2 edges after the first edge at which the new key_data value is present on the input, assuming an empty FIFO.
- FIFO:
  - out_code = head entry; out_valid = (count != 0).
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle when non-empty: count is unchanged and both take effect.
  - Push when full with no pop that cycle: event dropped, overflow pulses for one cycle, contents unchanged.
  - Push when full with a pop in the same cycle: accepted, no overflow.
  - Pointers wrap modulo FIFO_DEPTH.
- out_code is stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation flushes the FIFO and returns to IDLE. A key still held after reset release is reported once as a new press after debounce.

Test Plan:
- Clean press: key_data=12'h010 (key 5) for 40 cycles, then 0 -> exactly one transfer with out_code=4'h5; key_held high for the pressed interval; out_valid rises DEBOUNCE+2 edges after the input change.
- Bounce: key_data toggles 12'h001/0 every 3 cycles for 30 cycles, then stays 12'h001 for 30 cycles -> no event during toggling, then exactly one event with out_code=4'h1.
- Code map: press *, 0, # in sequence with releases and out_ready=1 -> out_codes 4'hA, 4'h0, 4'hB in order.
- Multi-hot: key_data=12'h006 held stable -> multi_err single pulse, no FIFO push; after release, key 9 (12'h100) -> out_code=4'h9.
- Overflow/backpressure: out_ready=0, five separate presses of keys 1..5 -> FIFO holds 1,2,3,4; overflow pulses once on the fifth; then out_ready=1 drains 1,2,3,4 and out_valid falls.
- Reset mid-press: assert rst low while PRESSED with 2 entries queued -> out_valid=0 immediately; after release of reset with key still held, exactly one new event is produced.
